// File: rtl/aes_host_seq.sv
// Command sequencer driving the AES core register port (4-bit addr, 16-bit write, 8-bit read).
// Define AES_HOST_SEQ_CFG_READBACK_EN to verify the CONFIG register by readback before the key burst.
module aes_host_seq #(
  parameter int unsigned POLL_TIMEOUT = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic         cmd_encdec,
  input  logic         cmd_keylen,
  input  logic         cmd_mode,
  input  logic [255:0] cmd_key,
  input  logic [127:0] cmd_iv,
  input  logic [127:0] cmd_blk,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         err,
  output logic         busy,
  output logic [3:0]   aes_address,
  output logic [15:0]  aes_data_in,
  input  logic [7:0]   aes_data_out
);
  localparam logic [3:0] ADDR_IDLE   = 4'd0;
  localparam logic [3:0] ADDR_CONFIG = 4'd1;
  localparam logic [3:0] ADDR_KEY    = 4'd2;
  localparam logic [3:0] ADDR_BLOCK  = 4'd3;
  localparam logic [3:0] ADDR_STATUS = 4'd5;
  localparam logic [3:0] ADDR_START  = 4'd6;
  localparam logic [3:0] ADDR_RESULT = 4'd7;
  localparam logic [3:0] ADDR_IV     = 4'd8;

  localparam logic [1:0] OP_KEY  = 2'd0;
  localparam logic [1:0] OP_IV   = 2'd1;
  localparam logic [1:0] OP_PROC = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_RB_CMD, S_RB_READ, S_HDR, S_DATA, S_START,
    S_POLL, S_RES_CMD, S_RES_DATA, S_RES_OUT
  } state_t;

  state_t        state;
  logic [1:0]    op_reg;
  logic          keylen_reg;
  logic [255:0]  burst_reg;
  logic [3:0]    cnt_reg;
  logic [31:0]   poll_cnt;
  logic [7:0]    poll_target;
`ifdef AES_HOST_SEQ_CFG_READBACK_EN
  logic [2:0]    cfg_reg;
`endif

  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign poll_target = (op_reg == OP_PROC) ? 8'h02 : 8'h01;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      op_reg      <= OP_KEY;
      keylen_reg  <= 1'b0;
      burst_reg   <= '0;
      cnt_reg     <= '0;
      poll_cnt    <= '0;
      aes_address <= ADDR_IDLE;
      aes_data_in <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      err         <= 1'b0;
`ifdef AES_HOST_SEQ_CFG_READBACK_EN
      cfg_reg     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_reg     <= cmd_op;
            keylen_reg <= cmd_keylen;
`ifdef AES_HOST_SEQ_CFG_READBACK_EN
            cfg_reg    <= {cmd_mode, cmd_keylen, cmd_encdec};
`endif
            case (cmd_op)
              OP_KEY: begin
                err         <= 1'b0;
                state       <= S_CFG;
                aes_address <= ADDR_CONFIG;
                aes_data_in <= {13'b0, cmd_mode, cmd_keylen, cmd_encdec};
                burst_reg   <= cmd_key;
              end
              OP_IV: begin
                err         <= 1'b0;
                state       <= S_HDR;
                aes_address <= ADDR_IV;
                aes_data_in <= '0;
                burst_reg   <= {cmd_iv, 128'd0};
              end
              OP_PROC: begin
                err         <= 1'b0;
                state       <= S_HDR;
                aes_address <= ADDR_BLOCK;
                aes_data_in <= '0;
                burst_reg   <= {cmd_blk, 128'd0};
              end
              default: ;  // reserved op: accepted and dropped
            endcase
          end
        end
        S_CFG: begin
          aes_data_in <= '0;
`ifdef AES_HOST_SEQ_CFG_READBACK_EN
          state       <= S_RB_CMD;
          aes_address <= ADDR_START;
`else
          state       <= S_HDR;
          aes_address <= ADDR_KEY;
`endif
        end
`ifdef AES_HOST_SEQ_CFG_READBACK_EN
        S_RB_CMD: begin
          state       <= S_RB_READ;
          aes_address <= ADDR_IDLE;
          aes_data_in <= '0;
        end
        S_RB_READ: begin
          if (aes_data_out == {3'b000, cfg_reg, 2'b00}) begin
            state       <= S_HDR;
            aes_address <= ADDR_KEY;
          end else begin
            err         <= 1'b1;
            state       <= S_IDLE;
            aes_address <= ADDR_IDLE;
          end
        end
`endif
        S_HDR: begin
          cnt_reg     <= (op_reg == OP_KEY && keylen_reg) ? 4'd15 : 4'd7;
          state       <= S_DATA;
          aes_address <= ADDR_IDLE;
          aes_data_in <= burst_reg[255:240];
          burst_reg   <= {burst_reg[239:0], 16'h0000};
        end
        S_DATA: begin
          if (cnt_reg == 4'd0) begin
            case (op_reg)
              OP_KEY: begin
                state       <= S_START;
                aes_address <= ADDR_START;
                aes_data_in <= 16'h0001;
              end
              OP_PROC: begin
                state       <= S_START;
                aes_address <= ADDR_START;
                aes_data_in <= 16'h0002;
              end
              default: begin
                state       <= S_IDLE;
                aes_address <= ADDR_IDLE;
                aes_data_in <= '0;
              end
            endcase
          end else begin
            cnt_reg     <= cnt_reg - 4'd1;
            aes_data_in <= burst_reg[255:240];
            burst_reg   <= {burst_reg[239:0], 16'h0000};
          end
        end
        S_START: begin
          state       <= S_POLL;
          aes_address <= ADDR_STATUS;
          aes_data_in <= '0;
          poll_cnt    <= '0;
        end
        S_POLL: begin
          // The first poll cycle still shows the core's pre-command status, so it is skipped.
          if (poll_cnt != 32'd0 && aes_data_out == poll_target) begin
            if (op_reg == OP_PROC) begin
              state       <= S_RES_CMD;
              aes_address <= ADDR_RESULT;
            end else begin
              state       <= S_IDLE;
              aes_address <= ADDR_IDLE;
            end
          end else if (poll_cnt == POLL_TIMEOUT) begin
            err         <= 1'b1;
            state       <= S_IDLE;
            aes_address <= ADDR_IDLE;
          end else begin
            poll_cnt <= poll_cnt + 32'd1;
          end
        end
        S_RES_CMD: begin
          state       <= S_RES_DATA;
          aes_address <= ADDR_IDLE;
          cnt_reg     <= 4'd15;
        end
        S_RES_DATA: begin
          res_data <= {res_data[119:0], aes_data_out};
          if (cnt_reg == 4'd0) begin
            state     <= S_RES_OUT;
            res_valid <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        S_RES_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          aes_address <= ADDR_IDLE;
          aes_data_in <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_host_seq.sv
// Scoreboard bench for aes_host_seq: a behavioural register-port core model answers the bus,
// and expected results come from the commanded key/IV/block via a stand-in block function.
`timescale 1ns/1ps
module tb_aes_host_seq;
  localparam int unsigned PT = 10;
`ifdef AES_HOST_SEQ_CFG_READBACK_EN
  localparam int RB = 2;
`else
  localparam int RB = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'd0;
  logic         cmd_encdec = 1'b0;
  logic         cmd_keylen = 1'b0;
  logic         cmd_mode = 1'b0;
  logic [255:0] cmd_key = '0;
  logic [127:0] cmd_iv = '0;
  logic [127:0] cmd_blk = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [127:0] res_data;
  logic         err;
  logic         busy;
  logic [3:0]   aes_address;
  logic [15:0]  aes_data_in;
  logic [7:0]   aes_data_out = 8'h00;

  always #5 clk = ~clk;

  aes_host_seq #(.POLL_TIMEOUT(PT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_encdec(cmd_encdec), .cmd_keylen(cmd_keylen), .cmd_mode(cmd_mode),
    .cmd_key(cmd_key), .cmd_iv(cmd_iv), .cmd_blk(cmd_blk),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err(err), .busy(busy),
    .aes_address(aes_address), .aes_data_in(aes_data_in), .aes_data_out(aes_data_out)
  );

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endfunction

  // Stand-in for the cipher: any function sensitive to every transferred halfword and config bit.
  function automatic logic [127:0] toy(input logic [255:0] k, input logic [2:0] cfg,
                                       input logic [127:0] iv, input logic [127:0] b);
    logic [127:0] lo;
    lo = cfg[1] ? k[127:0] : 128'd0;
    return b ^ k[255:128] ^ {lo[119:0], lo[127:120]} ^ (cfg[2] ? iv : 128'd0) ^ {125'd0, cfg};
  endfunction

  // ---------------- core model ----------------
  logic [255:0] c_key = '0;
  logic [127:0] c_iv = '0, c_blk = '0, c_res = '0;
  logic [2:0]   c_cfg = '0;
  logic [3:0]   c_tgt = '0;
  int           hw_cnt = 0, hw_lim = 8, rd_idx = 16, cd = 0, poll_run = 0, poll_last = 0;
  bit           rb_pend = 0, stuck = 0;
  logic [7:0]   status = 8'h00, want = 8'h00;

  always @(negedge clk) begin
    logic [3:0]  a;
    logic [15:0] d;
    a = aes_address;
    d = aes_data_in;
    if (a == 4'd5) aes_data_out = status;
    else if (a == 4'd0 && rd_idx < 16) begin
      aes_data_out = c_res[127 - 8*rd_idx -: 8];
      rd_idx++;
    end else if (a == 4'd0 && rb_pend) aes_data_out = {3'b000, c_cfg, 2'b00};
    else aes_data_out = 8'($urandom);
    rb_pend = 0;
    if (a == 4'd5) poll_run++;
    else if (poll_run != 0) begin
      poll_last = poll_run;
      poll_run = 0;
    end
    if (cd > 0) begin
      status = 8'h00;
      cd--;
      if (cd == 0 && !stuck) begin
        status = want;
        if (want == 8'h02) c_res = toy(c_key, c_cfg, c_iv, c_blk);
      end
    end
    case (a)
      4'd1: begin c_cfg = d[2:0]; c_tgt = '0; end
      4'd2, 4'd3, 4'd8: begin
        c_tgt = a;
        hw_cnt = 0;
        if (a == 4'd2) c_key = '0;
      end
      4'd0: if (c_tgt != 4'd0) begin
        hw_lim = (c_tgt == 4'd2 && c_cfg[1]) ? 16 : 8;
        if (hw_cnt < hw_lim) begin
          case (c_tgt)
            4'd2:    c_key[255 - 16*hw_cnt -: 16] = d;
            4'd3:    c_blk[127 - 16*hw_cnt -: 16] = d;
            default: c_iv[127 - 16*hw_cnt -: 16]  = d;
          endcase
        end
        hw_cnt++;
      end
      4'd6: begin
        if (c_tgt == 4'd2) chk("key_burst_len", hw_cnt, c_cfg[1] ? 16 : 8);
        if (c_tgt == 4'd3) chk("blk_burst_len", hw_cnt, 8);
        c_tgt = '0;
        if (d == 16'h0001) begin
          want = 8'h01; cd = $urandom_range(1, 6);
        end else if (d == 16'h0002) begin
          want = 8'h02; cd = $urandom_range(1, 6);
          c_res = {$urandom, $urandom, $urandom, $urandom};
        end else rb_pend = 1;
      end
      4'd7: begin c_tgt = '0; rd_idx = 0; end
      default: c_tgt = '0;
    endcase
  end

  // ---------------- result monitor ----------------
  int rv_cycles = 0;
  always @(negedge clk) begin
    logic [127:0] e;
    res_ready = ($urandom_range(0, 2) != 0);
    if (res_valid) rv_cycles++;
    if (res_valid && res_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got %h required no result", res_data);
      end else begin
        e = exp_q.pop_front();
        if (res_data !== e) begin
          errors++;
          $display("FAIL result: got %h required %h", res_data, e);
        end else $display("result %h matches", res_data);
      end
    end
  end

  // ---------------- reference state and stimulus ----------------
  logic [255:0] m_key = '0;
  logic [2:0]   m_cfg = '0;
  logic [127:0] m_iv = '0;

  task automatic issue(input logic [1:0] op, input logic [2:0] cfg, input logic [255:0] key,
                       input logic [127:0] iv, input logic [127:0] blk, output int cyc);
    chk("cmd_ready_before", cmd_ready, 1);
    cmd_op = op; cmd_encdec = cfg[0]; cmd_keylen = cfg[1]; cmd_mode = cfg[2];
    cmd_key = key; cmd_iv = iv; cmd_blk = blk; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_key = {8{$urandom}}; cmd_iv = {4{$urandom}}; cmd_blk = {4{$urandom}};
    cyc = 0;
    @(negedge clk); #1;
    while (busy && cyc < 3000) begin
      cyc++;
      @(negedge clk); #1;
    end
    chk("cmd_done", busy, 0);
  endtask

  task automatic load_key(input logic [2:0] cfg, input logic [255:0] key, input bit ok);
    int cyc;
    issue(2'd0, cfg, key, '0, '0, cyc);
    if (ok) begin
      chk("key_err", err, 0);
      chk("key_cycles", cyc, (cfg[1] ? 19 : 11) + RB + poll_last);
      m_key = key;
      m_cfg = cfg;
    end
    $display("LOAD_KEY cfg=%b cycles=%0d err=%0b", cfg, cyc, err);
  endtask

  task automatic load_iv(input logic [127:0] iv);
    int cyc;
    issue(2'd1, 3'b000, '0, iv, '0, cyc);
    chk("iv_err", err, 0);
    chk("iv_cycles", cyc, 9);
    m_iv = iv;
    $display("LOAD_IV iv=%h cycles=%0d", iv, cyc);
  endtask

  task automatic process(input logic [127:0] blk, input bit ok);
    int cyc;
    if (ok) exp_q.push_back(toy(m_key, m_cfg, m_iv, blk));
    rv_cycles = 0;
    issue(2'd2, 3'b000, '0, '0, blk, cyc);
    if (ok) begin
      chk("proc_err", err, 0);
      chk("proc_cycles", cyc, 27 + poll_last + rv_cycles);
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("PROCESS blk=%h cycles=%0d err=%0b", blk, cyc, err);
  endtask

  task automatic reserved();
    int   cyc;
    logic e0;
    e0 = err;
    issue(2'd3, 3'($urandom), '0, '0, '0, cyc);
    chk("rsv_cycles", cyc, 0);
    chk("rsv_err", err, e0);
    chk("rsv_addr", aes_address, 0);
    $display("RESERVED cycles=%0d err=%0b", cyc, err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] k;
    logic [2:0]   cfg;
    int           cyc;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_addr", aes_address, 0);
    chk("rst_data_in", aes_data_in, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_ready", cmd_ready, 1);

    load_key(3'b001, {128'h000102030405060708090a0b0c0d0e0f, 128'hdeadbeef}, 1);
    process(128'h00112233445566778899aabbccddeeff, 1);
    process(128'h0123456789abcdeffedcba9876543210, 1);
    load_key(3'b011, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1);
    process(128'h00112233445566778899aabbccddeeff, 1);
    load_iv({4{$urandom}});
    load_key(3'b111, {8{$urandom}}, 1);
    process({4{$urandom}}, 1);
    process({4{$urandom}}, 1);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0: begin cfg = 3'($urandom); k = {8{$urandom}}; load_key(cfg, k, 1); end
        1: load_iv({4{$urandom}});
        2: reserved();
        default: process({4{$urandom}}, 1);
      endcase
    end

    // core never reports completion
    stuck = 1;
    process({4{$urandom}}, 0);
    chk("to_err", err, 1);
    chk("to_polls", poll_last, PT + 1);
    chk("to_addr", aes_address, 0);
    chk("to_ready", cmd_ready, 1);
    chk("to_no_result", rv_cycles, 0);
    reserved();
    load_iv({4{$urandom}});
    issue(2'd0, 3'b010, {8{$urandom}}, '0, '0, cyc);
    chk("key_to_err", err, 1);
    chk("key_to_cycles", cyc, 19 + RB + PT + 1);
    stuck = 0;

    // reset in the middle of the key burst
    cmd_op = 2'd0; cmd_encdec = 1'b1; cmd_keylen = 1'b1; cmd_mode = 1'b0;
    cmd_key = {8{$urandom}}; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (c_tgt == 4'd2 && hw_cnt == 5) break;
      @(negedge clk); #1;
    end
    chk("rst_mid_burst_reached", hw_cnt, 5);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_addr", aes_address, 0);
    chk("mid_rst_data_in", aes_data_in, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk); #1;
    load_key(3'b011, {8{$urandom}}, 1);
    process({4{$urandom}}, 1);
    load_key(3'b000, {8{$urandom}}, 1);
    process({4{$urandom}}, 1);

    repeat (5) @(negedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_host_seq.md
# aes_host_seq

Host-side command sequencer that drives the AES core's 4-bit address / 16-bit write / 8-bit read register port. It turns three high-level commands into the exact cycle-by-cycle address and data sequence the core expects: load config+key, load IV, process one 128-bit block. It sits between a streaming data source (image DMA, UART bridge) and the AES core, replacing software polling.

## Interface
- POLL_TIMEOUT, 32, max STATUS-poll cycles before abort (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0 LOAD_KEY, 1 LOAD_IV, 2 PROCESS, 3 reserved (accepted, ignored)
- cmd_encdec / cmd_keylen / cmd_mode  in  1 each  1=enc / 1=256-bit / 1=CBC; used by LOAD_KEY
- cmd_key  in  256  key; [255:128] only when cmd_keylen=0
- cmd_iv  in  128  IV, MSB halfword first
- cmd_blk  in  128  input block
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_data  out  128  result block, byte 0 at [127:120]
- err  out  1  sticky abort flag; cleared on next accepted command
- busy  out  1  state ≠ IDLE
- aes_address  out  4  core address (registered)
- aes_data_in  out  16  core write data (registered)
- aes_data_out  in  8  core read data

## Operation
- Core addresses: IDLE 0, CONFIG 1, KEY 2, BLOCK 3, STATUS 5, START 6, RESULT 7, IV 8.
- Command accepted on cmd_valid & cmd_ready; all cmd_* fields latched that edge.
- Burst write: one cycle address=X, data_in=0; then N cycles address=IDLE, data_in=successive halfwords MSB first.
- LOAD_KEY: CFG (addr 1, data_in={13'b0,mode,keylen,encdec}) → KEY burst (8 halfwords for 128, 16 for 256) → INIT (addr 6, data_in=16'h0001) → POLL_RDY (addr 5, data_in=0, wait aes_data_out==8'h01) → IDLE.
- LOAD_IV: IV burst, 8 halfwords → IDLE.
- PROCESS: BLOCK burst, 8 halfwords → NEXT (addr 6, data_in=16'h0002) → POLL_VLD (addr 5, wait 8'h02) → RES_CMD (addr 7) → RES_DATA (16 cycles, addr 0, capture aes_data_out each cycle into byte k) → RES_OUT (res_valid=1 until res_ready) → IDLE.
- Polling: first cycle in POLL_* discarded; compare each following cycle; exact 8-bit match required.
- Timeout: poll counter reaches POLL_TIMEOUT with no match → err=1, aes_address=0, → IDLE, no res_valid.
- Reserved op: one cycle in IDLE, no bus activity, err unchanged.
- Sequencer enforces no ordering; PROCESS before LOAD_KEY is a user error detected only by timeout.

## Timing
- Reset values: aes_address=0, aes_data_in=0, res_valid=0, res_data=0, err=0, busy=0; cmd_ready=1 first cycle after rst deasserts.
- aes_address/aes_data_in change only on clk edge; core sees each value for exactly one cycle except polls and RES_OUT (address held 0).
- RESULT byte k (0..15) valid on aes_data_out during RES_DATA cycle k; sampled at that cycle's closing edge.
- Fixed cycles excl. polls: LOAD_KEY 128 = 11, 256 = 19; LOAD_IV = 9; PROCESS = 27 + res_ready wait.
- res_ready high in same cycle res_valid rises → result consumed, IDLE next cycle.
- rst mid-sequence: all state/outputs return to reset values next edge; partially-written burst abandoned; core must be reconfigured via LOAD_KEY.
- cmd_valid ignored while busy; no queuing.

## Configuration
- AES_HOST_SEQ_CFG_READBACK_EN defined: after CFG, one cycle addr 6 data_in 0, then one cycle addr 0; aes_data_out sampled in that cycle must equal {3'b000, mode, keylen, encdec, 2'b00}; mismatch → err=1, abort to IDLE. LOAD_KEY fixed cycles +2.
- Undefined: CFG proceeds directly to KEY burst; no readback, no config error.

## Test plan
- LOAD_KEY enc/128/ECB key 000102..0f, PROCESS 00112233445566778899aabbccddeeff → res_data 69c4e0d86a7b0430d8cdb78070b4c55a, err=0.
- LOAD_KEY enc/256/ECB key 000102..1f, same block → 8ea2b7ca516745bfeafc49904b496089; dec/256 on that ciphertext → plaintext back.
- CBC enc/256: LOAD_KEY, LOAD_IV, 50 PROCESS commands from data_CBC_256 → all match golden_CBC_256; then dec pass → original plaintext.
- Core model never asserts valid → err=1 after POLL_TIMEOUT+1 poll cycles, aes_address=0, res_valid never high, cmd_ready=1.
- rst asserted during KEY burst halfword 5 → next cycle aes_address=0, busy=0; fresh LOAD_KEY then PROCESS gives correct result.
- With AES_HOST_SEQ_CFG_READBACK_EN, core model returns 8'h00 on readback → err=1, no KEY address issued; enc/256/CBC correct model returns 8'b00011100 → proceeds.
